// File: rtl/hld_mem_pkg.sv
// Shared definitions for the HLD memory-channel multiplexer.
//   - Payload widths of the four request/response streams.
//   - Position of the tag bit that carries the source channel index.
//   - Channel index type used by the arbiter.
package hld_mem_pkg;

    localparam int NCH        = 2;
    localparam int TAG_W      = 16;
    localparam int TAG_CH_BIT = 15;

    localparam int RD_REQ_W   = 80;   // {addr[79:16], tag[15:0]}
    localparam int RD_RESP_W  = 528;  // {data[527:16], tag[15:0]}
    localparam int WR_REQ_W   = 606;  // {payload[605:16], tag[15:0]}
    localparam int WR_RESP_W  = 17;   // {flag[16], tag[15:0]}

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

endpackage

// File: rtl/rr_arb_reg2.sv
// Two-input round-robin arbiter feeding a one-entry output register.
// The accepted word is auto-tagged: bit TAG_CH_BIT is forced to the
// index of the channel it came from.
//   a_clk, rst            : clock, synchronous active-low reset
//   in_{0,1}_valid/ready  : per-channel request handshake
//   in_{0,1}_bits [W-1:0] : per-channel request word
//   out_valid/ready/bits  : merged, tagged request
module rr_arb_reg2
    import hld_mem_pkg::*;
#(
    parameter int W = RD_REQ_W
) (
    input  logic         a_clk,
    input  logic         rst,
    input  logic         in_0_valid,
    output logic         in_0_ready,
    input  logic [W-1:0] in_0_bits,
    input  logic         in_1_valid,
    output logic         in_1_ready,
    input  logic [W-1:0] in_1_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bits
);

    logic         out_full;
    ch_e          last_served;
    ch_e          grant;
    logic         can_load;
    logic         load;
    logic [W-1:0] sel_bits;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        grant = CH0;
        if (in_0_valid && in_1_valid)
            grant = (last_served == CH0) ? CH1 : CH0;
        else if (in_1_valid)
            grant = CH1;

        // Room exists when empty or when the held word leaves this cycle.
        // Readies stay low during reset so nothing is accepted then.
        can_load   = rst && (!out_full || out_ready);

        // Only a requesting channel is ever readied, so an idle channel
        // never sees a stray ready while the other is being served.
        in_0_ready = can_load && in_0_valid && (grant == CH0);
        in_1_ready = can_load && in_1_valid && (grant == CH1);
        load       = in_0_ready || in_1_ready;

        sel_bits             = (grant == CH1) ? in_1_bits : in_0_bits;
        sel_bits[TAG_CH_BIT] = (grant == CH1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge a_clk) begin
        if (!rst) begin
            out_full    <= 1'b0;
            last_served <= CH1;       // channel 0 wins the first contest
        end else if (load) begin
            out_full    <= 1'b1;      // load (with or without unload) keeps it full
            last_served <= grant;
        end else if (out_ready) begin
            out_full    <= 1'b0;
        end
    end

    // NOTE: the data register has no reset; out_full alone qualifies it,
    // so clearing the wide payload would only cost reset fan-out.
    always_ff @(posedge a_clk) begin
        if (load)
            out_bits <= sel_bits;
    end

    assign out_valid = out_full;

endmodule

// File: rtl/multi_channel_mux_2x2.sv
// Merges two accelerator memory channels onto one memory interface.
// Read and write requests are arbitrated independently (round-robin,
// one register stage, source channel written into tag bit TAG_CH_BIT).
// Responses are steered back combinationally by that tag bit, which is
// cleared before delivery.
//   a_clk, rst                    : clock, synchronous active-low reset
//   acc_rd_req_in_{0,1}_*  (80)   : per-channel read requests
//   mem_rd_req_out_*       (80)   : merged read request
//   mem_rd_resp_in_*       (528)  : read response from memory
//   acc_rd_resp_out_{0,1}_*(528)  : per-channel read responses
//   acc_wr_req_in_{0,1}_*  (606)  : per-channel write requests
//   mem_wr_req_out_*       (606)  : merged write request
//   mem_wr_resp_in_*       (17)   : write response from memory
//   acc_wr_resp_out_{0,1}_*(17)   : per-channel write responses
module multi_channel_mux_2x2
    import hld_mem_pkg::*;
(
    input  logic                 a_clk,
    input  logic                 rst,

    input  logic                 acc_rd_req_in_0_valid,
    output logic                 acc_rd_req_in_0_ready,
    input  logic [RD_REQ_W-1:0]  acc_rd_req_in_0_bits,
    input  logic                 acc_rd_req_in_1_valid,
    output logic                 acc_rd_req_in_1_ready,
    input  logic [RD_REQ_W-1:0]  acc_rd_req_in_1_bits,
    output logic                 mem_rd_req_out_valid,
    input  logic                 mem_rd_req_out_ready,
    output logic [RD_REQ_W-1:0]  mem_rd_req_out_bits,

    input  logic                 mem_rd_resp_in_valid,
    output logic                 mem_rd_resp_in_ready,
    input  logic [RD_RESP_W-1:0] mem_rd_resp_in_bits,
    output logic                 acc_rd_resp_out_0_valid,
    input  logic                 acc_rd_resp_out_0_ready,
    output logic [RD_RESP_W-1:0] acc_rd_resp_out_0_bits,
    output logic                 acc_rd_resp_out_1_valid,
    input  logic                 acc_rd_resp_out_1_ready,
    output logic [RD_RESP_W-1:0] acc_rd_resp_out_1_bits,

    input  logic                 acc_wr_req_in_0_valid,
    output logic                 acc_wr_req_in_0_ready,
    input  logic [WR_REQ_W-1:0]  acc_wr_req_in_0_bits,
    input  logic                 acc_wr_req_in_1_valid,
    output logic                 acc_wr_req_in_1_ready,
    input  logic [WR_REQ_W-1:0]  acc_wr_req_in_1_bits,
    output logic                 mem_wr_req_out_valid,
    input  logic                 mem_wr_req_out_ready,
    output logic [WR_REQ_W-1:0]  mem_wr_req_out_bits,

    input  logic                 mem_wr_resp_in_valid,
    output logic                 mem_wr_resp_in_ready,
    input  logic [WR_RESP_W-1:0] mem_wr_resp_in_bits,
    output logic                 acc_wr_resp_out_0_valid,
    input  logic                 acc_wr_resp_out_0_ready,
    output logic [WR_RESP_W-1:0] acc_wr_resp_out_0_bits,
    output logic                 acc_wr_resp_out_1_valid,
    input  logic                 acc_wr_resp_out_1_ready,
    output logic [WR_RESP_W-1:0] acc_wr_resp_out_1_bits
);

    rr_arb_reg2 #(.W(RD_REQ_W)) u_rd_req (
        .a_clk      (a_clk),
        .rst        (rst),
        .in_0_valid (acc_rd_req_in_0_valid),
        .in_0_ready (acc_rd_req_in_0_ready),
        .in_0_bits  (acc_rd_req_in_0_bits),
        .in_1_valid (acc_rd_req_in_1_valid),
        .in_1_ready (acc_rd_req_in_1_ready),
        .in_1_bits  (acc_rd_req_in_1_bits),
        .out_valid  (mem_rd_req_out_valid),
        .out_ready  (mem_rd_req_out_ready),
        .out_bits   (mem_rd_req_out_bits)
    );

    rr_arb_reg2 #(.W(WR_REQ_W)) u_wr_req (
        .a_clk      (a_clk),
        .rst        (rst),
        .in_0_valid (acc_wr_req_in_0_valid),
        .in_0_ready (acc_wr_req_in_0_ready),
        .in_0_bits  (acc_wr_req_in_0_bits),
        .in_1_valid (acc_wr_req_in_1_valid),
        .in_1_ready (acc_wr_req_in_1_ready),
        .in_1_bits  (acc_wr_req_in_1_bits),
        .out_valid  (mem_wr_req_out_valid),
        .out_ready  (mem_wr_req_out_ready),
        .out_bits   (mem_wr_req_out_bits)
    );

    // Response demux: the tag bit selects the destination channel. Data
    // reaches both outputs unchanged apart from the cleared tag bit; only
    // the valids are steered, and they are held low while in reset.
    logic                 rd_ch;
    logic                 wr_ch;
    logic [RD_RESP_W-1:0] rd_resp_bits;
    logic [WR_RESP_W-1:0] wr_resp_bits;

    always_comb begin
        rd_ch = mem_rd_resp_in_bits[TAG_CH_BIT];
        wr_ch = mem_wr_resp_in_bits[TAG_CH_BIT];

        rd_resp_bits             = mem_rd_resp_in_bits;
        rd_resp_bits[TAG_CH_BIT] = 1'b0;
        wr_resp_bits             = mem_wr_resp_in_bits;
        wr_resp_bits[TAG_CH_BIT] = 1'b0;

        acc_rd_resp_out_0_valid = rst && mem_rd_resp_in_valid && !rd_ch;
        acc_rd_resp_out_1_valid = rst && mem_rd_resp_in_valid &&  rd_ch;
        acc_rd_resp_out_0_bits  = rd_resp_bits;
        acc_rd_resp_out_1_bits  = rd_resp_bits;
        mem_rd_resp_in_ready    = rd_ch ? acc_rd_resp_out_1_ready
                                        : acc_rd_resp_out_0_ready;

        acc_wr_resp_out_0_valid = rst && mem_wr_resp_in_valid && !wr_ch;
        acc_wr_resp_out_1_valid = rst && mem_wr_resp_in_valid &&  wr_ch;
        acc_wr_resp_out_0_bits  = wr_resp_bits;
        acc_wr_resp_out_1_bits  = wr_resp_bits;
        mem_wr_resp_in_ready    = wr_ch ? acc_wr_resp_out_1_ready
                                        : acc_wr_resp_out_0_ready;
    end

endmodule

// File: tb/tb_multi_channel_mux_2x2.sv
// Self-checking bench for multi_channel_mux_2x2: scoreboarded request
// paths, hand-written reset/round-robin/back-pressure sequences and a
// vector table for the response demux.
module tb_multi_channel_mux_2x2;
    import hld_mem_pkg::*;

    logic a_clk = 1'b0;
    logic rst;
    always #5 a_clk = ~a_clk;

    logic                 acc_rd_req_in_0_valid, acc_rd_req_in_0_ready;
    logic [RD_REQ_W-1:0]  acc_rd_req_in_0_bits;
    logic                 acc_rd_req_in_1_valid, acc_rd_req_in_1_ready;
    logic [RD_REQ_W-1:0]  acc_rd_req_in_1_bits;
    logic                 mem_rd_req_out_valid, mem_rd_req_out_ready;
    logic [RD_REQ_W-1:0]  mem_rd_req_out_bits;
    logic                 mem_rd_resp_in_valid, mem_rd_resp_in_ready;
    logic [RD_RESP_W-1:0] mem_rd_resp_in_bits;
    logic                 acc_rd_resp_out_0_valid, acc_rd_resp_out_0_ready;
    logic [RD_RESP_W-1:0] acc_rd_resp_out_0_bits;
    logic                 acc_rd_resp_out_1_valid, acc_rd_resp_out_1_ready;
    logic [RD_RESP_W-1:0] acc_rd_resp_out_1_bits;
    logic                 acc_wr_req_in_0_valid, acc_wr_req_in_0_ready;
    logic [WR_REQ_W-1:0]  acc_wr_req_in_0_bits;
    logic                 acc_wr_req_in_1_valid, acc_wr_req_in_1_ready;
    logic [WR_REQ_W-1:0]  acc_wr_req_in_1_bits;
    logic                 mem_wr_req_out_valid, mem_wr_req_out_ready;
    logic [WR_REQ_W-1:0]  mem_wr_req_out_bits;
    logic                 mem_wr_resp_in_valid, mem_wr_resp_in_ready;
    logic [WR_RESP_W-1:0] mem_wr_resp_in_bits;
    logic                 acc_wr_resp_out_0_valid, acc_wr_resp_out_0_ready;
    logic [WR_RESP_W-1:0] acc_wr_resp_out_0_bits;
    logic                 acc_wr_resp_out_1_valid, acc_wr_resp_out_1_ready;
    logic [WR_RESP_W-1:0] acc_wr_resp_out_1_bits;

    multi_channel_mux_2x2 dut (
        .a_clk                   (a_clk),
        .rst                     (rst),
        .acc_rd_req_in_0_valid   (acc_rd_req_in_0_valid),
        .acc_rd_req_in_0_ready   (acc_rd_req_in_0_ready),
        .acc_rd_req_in_0_bits    (acc_rd_req_in_0_bits),
        .acc_rd_req_in_1_valid   (acc_rd_req_in_1_valid),
        .acc_rd_req_in_1_ready   (acc_rd_req_in_1_ready),
        .acc_rd_req_in_1_bits    (acc_rd_req_in_1_bits),
        .mem_rd_req_out_valid    (mem_rd_req_out_valid),
        .mem_rd_req_out_ready    (mem_rd_req_out_ready),
        .mem_rd_req_out_bits     (mem_rd_req_out_bits),
        .mem_rd_resp_in_valid    (mem_rd_resp_in_valid),
        .mem_rd_resp_in_ready    (mem_rd_resp_in_ready),
        .mem_rd_resp_in_bits     (mem_rd_resp_in_bits),
        .acc_rd_resp_out_0_valid (acc_rd_resp_out_0_valid),
        .acc_rd_resp_out_0_ready (acc_rd_resp_out_0_ready),
        .acc_rd_resp_out_0_bits  (acc_rd_resp_out_0_bits),
        .acc_rd_resp_out_1_valid (acc_rd_resp_out_1_valid),
        .acc_rd_resp_out_1_ready (acc_rd_resp_out_1_ready),
        .acc_rd_resp_out_1_bits  (acc_rd_resp_out_1_bits),
        .acc_wr_req_in_0_valid   (acc_wr_req_in_0_valid),
        .acc_wr_req_in_0_ready   (acc_wr_req_in_0_ready),
        .acc_wr_req_in_0_bits    (acc_wr_req_in_0_bits),
        .acc_wr_req_in_1_valid   (acc_wr_req_in_1_valid),
        .acc_wr_req_in_1_ready   (acc_wr_req_in_1_ready),
        .acc_wr_req_in_1_bits    (acc_wr_req_in_1_bits),
        .mem_wr_req_out_valid    (mem_wr_req_out_valid),
        .mem_wr_req_out_ready    (mem_wr_req_out_ready),
        .mem_wr_req_out_bits     (mem_wr_req_out_bits),
        .mem_wr_resp_in_valid    (mem_wr_resp_in_valid),
        .mem_wr_resp_in_ready    (mem_wr_resp_in_ready),
        .mem_wr_resp_in_bits     (mem_wr_resp_in_bits),
        .acc_wr_resp_out_0_valid (acc_wr_resp_out_0_valid),
        .acc_wr_resp_out_0_ready (acc_wr_resp_out_0_ready),
        .acc_wr_resp_out_0_bits  (acc_wr_resp_out_0_bits),
        .acc_wr_resp_out_1_valid (acc_wr_resp_out_1_valid),
        .acc_wr_resp_out_1_ready (acc_wr_resp_out_1_ready),
        .acc_wr_resp_out_1_bits  (acc_wr_resp_out_1_bits)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [RD_REQ_W-1:0] rd_q[$];
    logic [WR_REQ_W-1:0] wr_q[$];

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Random word with the tag channel bit cleared, as accelerators issue.
    function automatic logic [639:0] rnd_word();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom();
        r[TAG_CH_BIT] = 1'b0;
        return r;
    endfunction

    function automatic logic [RD_REQ_W-1:0] tag_rd(input logic [RD_REQ_W-1:0] b, input logic ch);
        b[TAG_CH_BIT] = ch;
        return b;
    endfunction

    function automatic logic [WR_REQ_W-1:0] tag_wr(input logic [WR_REQ_W-1:0] b, input logic ch);
        b[TAG_CH_BIT] = ch;
        return b;
    endfunction

    // Scoreboard: expected words are queued when an input handshake is seen
    // and compared when the merged output handshakes. A reset empties the
    // request register, so the queues are dropped with it.
    always @(negedge a_clk) begin
        if (rst !== 1'b1) begin
            rd_q.delete();
            wr_q.delete();
        end else begin
            if (mem_rd_req_out_valid && mem_rd_req_out_ready) begin
                if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_req_unexpected: actual=%0h required=none", mem_rd_req_out_bits);
                end else begin
                    check("rd_req_sb", mem_rd_req_out_bits, rd_q.pop_front());
                end
            end
            if (mem_wr_req_out_valid && mem_wr_req_out_ready) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wr_req_unexpected: actual=%0h required=none", mem_wr_req_out_bits);
                end else begin
                    check("wr_req_sb", mem_wr_req_out_bits, wr_q.pop_front());
                end
            end
            if (acc_rd_req_in_0_valid && acc_rd_req_in_0_ready) rd_q.push_back(tag_rd(acc_rd_req_in_0_bits, 1'b0));
            if (acc_rd_req_in_1_valid && acc_rd_req_in_1_ready) rd_q.push_back(tag_rd(acc_rd_req_in_1_bits, 1'b1));
            if (acc_wr_req_in_0_valid && acc_wr_req_in_0_ready) wr_q.push_back(tag_wr(acc_wr_req_in_0_bits, 1'b0));
            if (acc_wr_req_in_1_valid && acc_wr_req_in_1_ready) wr_q.push_back(tag_wr(acc_wr_req_in_1_bits, 1'b1));
        end
    end

    typedef struct {
        logic        rd_v;  logic [15:0] rd_tag; logic rd_r0; logic rd_r1;
        logic        wr_v;  logic [16:0] wr_b;   logic wr_r0; logic wr_r1;
        logic [1:0]  exp_rd_v;  logic [15:0] exp_rd_tag; logic exp_rd_mr;
        logic [1:0]  exp_wr_v;  logic [16:0] exp_wr_b;   logic exp_wr_mr;
    } resp_vec_t;

    resp_vec_t          vecs[4];
    logic [WR_REQ_W-1:0] held;
    logic [511:0]        rd_data;
    logic [639:0]        tmp;

    initial begin
        // exp_*_v is {ch1, ch0}
        vecs[0] = '{1'b1, 16'h8005, 1'b1, 1'b1, 1'b1, 17'h00003, 1'b1, 1'b1,
                    2'b10, 16'h0005, 1'b1, 2'b01, 17'h00003, 1'b1};
        vecs[1] = '{1'b1, 16'h8005, 1'b1, 1'b0, 1'b1, 17'h18003, 1'b1, 1'b1,
                    2'b10, 16'h0005, 1'b0, 2'b10, 17'h10003, 1'b1};
        vecs[2] = '{1'b0, 16'h8005, 1'b1, 1'b1, 1'b0, 17'h00003, 1'b0, 1'b1,
                    2'b00, 16'h0005, 1'b1, 2'b00, 17'h00003, 1'b0};
        vecs[3] = '{1'b1, 16'h7fff, 1'b0, 1'b1, 1'b1, 17'h0ffff, 1'b1, 1'b0,
                    2'b01, 16'h7fff, 1'b0, 2'b10, 17'h07fff, 1'b0};

        rst = 1'b0;
        mem_rd_req_out_ready = 1'b1; mem_wr_req_out_ready = 1'b1;
        acc_rd_resp_out_0_ready = 1'b1; acc_rd_resp_out_1_ready = 1'b1;
        acc_wr_resp_out_0_ready = 1'b1; acc_wr_resp_out_1_ready = 1'b1;
        mem_rd_resp_in_valid = 1'b0; mem_rd_resp_in_bits = '0;
        mem_wr_resp_in_valid = 1'b0; mem_wr_resp_in_bits = '0;
        tmp = rnd_word(); acc_rd_req_in_0_bits = tmp[RD_REQ_W-1:0];
        tmp = rnd_word(); acc_rd_req_in_1_bits = tmp[RD_REQ_W-1:0];
        tmp = rnd_word(); acc_wr_req_in_0_bits = tmp[WR_REQ_W-1:0];
        tmp = rnd_word(); acc_wr_req_in_1_bits = tmp[WR_REQ_W-1:0];
        acc_rd_req_in_0_valid = 1'b1; acc_rd_req_in_1_valid = 1'b1;
        acc_wr_req_in_0_valid = 1'b1; acc_wr_req_in_1_valid = 1'b1;

        // Reset held for 3 cycles with every input requesting.
        repeat (3) begin
            @(negedge a_clk);
            check("rst_out_valid", {mem_rd_req_out_valid, mem_wr_req_out_valid}, 2'b00);
            check("rst_in_ready", {acc_rd_req_in_0_ready, acc_rd_req_in_1_ready,
                                   acc_wr_req_in_0_ready, acc_wr_req_in_1_ready}, 4'b0000);
        end
        @(posedge a_clk); #1 rst = 1'b1;
        @(negedge a_clk);
        check("first_grant_rd", {acc_rd_req_in_1_ready, acc_rd_req_in_0_ready}, 2'b01);
        check("first_grant_wr", {acc_wr_req_in_1_ready, acc_wr_req_in_0_ready}, 2'b01);
        @(posedge a_clk); #1;
        acc_rd_req_in_0_valid = 1'b0; acc_rd_req_in_1_valid = 1'b0;
        acc_wr_req_in_0_valid = 1'b0; acc_wr_req_in_1_valid = 1'b0;
        @(negedge a_clk);
        check("first_out_valid", {mem_rd_req_out_valid, mem_wr_req_out_valid}, 2'b11);

        // Single channel: ch1 read, tag bit 15 set on the way out.
        @(posedge a_clk); #1;
        acc_rd_req_in_1_bits  = {64'h1000, 16'h0005};
        acc_rd_req_in_1_valid = 1'b1;
        @(negedge a_clk);
        check("single_ready", {acc_rd_req_in_1_ready, acc_rd_req_in_0_ready}, 2'b10);
        @(posedge a_clk); #1 acc_rd_req_in_1_valid = 1'b0;
        @(negedge a_clk);
        check("single_out", {mem_rd_req_out_valid, mem_rd_req_out_bits}, {1'b1, 64'h1000, 16'h8005});
        check("single_ch0_ready", acc_rd_req_in_0_ready, 1'b0);

        // Contention: both channels always valid, 1 word per cycle, alternating.
        @(posedge a_clk); #1;
        acc_rd_req_in_0_valid = 1'b1; acc_rd_req_in_1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge a_clk);
            check("rr_grant", {acc_rd_req_in_1_ready, acc_rd_req_in_0_ready},
                  (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0)
                check("rr_out", {mem_rd_req_out_valid, mem_rd_req_out_bits[TAG_CH_BIT]},
                      {1'b1, 1'((i - 1) % 2)});
            @(posedge a_clk); #1;
            tmp = rnd_word();
            if (i % 2 == 0) acc_rd_req_in_0_bits = tmp[RD_REQ_W-1:0];
            else            acc_rd_req_in_1_bits = tmp[RD_REQ_W-1:0];
        end
        acc_rd_req_in_0_valid = 1'b0; acc_rd_req_in_1_valid = 1'b0;
        @(negedge a_clk);
        check("rr_out_last", {mem_rd_req_out_valid, mem_rd_req_out_bits[TAG_CH_BIT]}, 2'b11);

        // Write back-pressure: ch1 wins (ch0 served last), register holds for 5 cycles.
        @(posedge a_clk); #1;
        mem_wr_req_out_ready = 1'b0;
        tmp = rnd_word(); acc_wr_req_in_0_bits = tmp[WR_REQ_W-1:0];
        tmp = rnd_word(); acc_wr_req_in_1_bits = tmp[WR_REQ_W-1:0];
        held = tag_wr(acc_wr_req_in_1_bits, 1'b1);
        acc_wr_req_in_0_valid = 1'b1; acc_wr_req_in_1_valid = 1'b1;
        @(negedge a_clk);
        check("bp_first_grant", {acc_wr_req_in_1_ready, acc_wr_req_in_0_ready}, 2'b10);
        repeat (5) begin
            @(posedge a_clk); #1;
            tmp = rnd_word(); acc_wr_req_in_1_bits = tmp[WR_REQ_W-1:0];
            @(negedge a_clk);
            check("bp_hold", {mem_wr_req_out_valid, mem_wr_req_out_bits}, {1'b1, held});
            check("bp_ready", {acc_wr_req_in_1_ready, acc_wr_req_in_0_ready}, 2'b00);
        end
        @(posedge a_clk); #1 mem_wr_req_out_ready = 1'b1;
        @(negedge a_clk);
        check("bp_resume", {mem_wr_req_out_valid, acc_wr_req_in_1_ready, acc_wr_req_in_0_ready}, 3'b101);
        check("bp_resume_bits", mem_wr_req_out_bits, held);
        @(posedge a_clk); #1;
        acc_wr_req_in_0_valid = 1'b0; acc_wr_req_in_1_valid = 1'b0;
        @(negedge a_clk);
        check("bp_after", {mem_wr_req_out_valid, mem_wr_req_out_bits[TAG_CH_BIT]}, 2'b10);

        // Response demux table.
        for (int i = 0; i < 4; i++) begin
            @(posedge a_clk); #1;
            tmp = rnd_word(); rd_data = tmp[511:0];
            mem_rd_resp_in_valid    = vecs[i].rd_v;
            mem_rd_resp_in_bits     = {rd_data, vecs[i].rd_tag};
            acc_rd_resp_out_0_ready = vecs[i].rd_r0;
            acc_rd_resp_out_1_ready = vecs[i].rd_r1;
            mem_wr_resp_in_valid    = vecs[i].wr_v;
            mem_wr_resp_in_bits     = vecs[i].wr_b;
            acc_wr_resp_out_0_ready = vecs[i].wr_r0;
            acc_wr_resp_out_1_ready = vecs[i].wr_r1;
            @(negedge a_clk);
            check("rd_resp_valid", {acc_rd_resp_out_1_valid, acc_rd_resp_out_0_valid}, vecs[i].exp_rd_v);
            check("rd_resp_bits0", acc_rd_resp_out_0_bits, {rd_data, vecs[i].exp_rd_tag});
            check("rd_resp_bits1", acc_rd_resp_out_1_bits, {rd_data, vecs[i].exp_rd_tag});
            check("rd_resp_ready", mem_rd_resp_in_ready, vecs[i].exp_rd_mr);
            check("wr_resp_valid", {acc_wr_resp_out_1_valid, acc_wr_resp_out_0_valid}, vecs[i].exp_wr_v);
            check("wr_resp_bits", {acc_wr_resp_out_1_bits, acc_wr_resp_out_0_bits},
                  {vecs[i].exp_wr_b, vecs[i].exp_wr_b});
            check("wr_resp_ready", mem_wr_resp_in_ready, vecs[i].exp_wr_mr);
        end

        // Reset mid-operation: pending read request is dropped, response valids gated.
        @(posedge a_clk); #1;
        acc_rd_resp_out_0_ready = 1'b1; acc_rd_resp_out_1_ready = 1'b1;
        mem_rd_resp_in_valid = 1'b1;
        mem_rd_resp_in_bits  = {512'h0, 16'h8005};
        mem_wr_resp_in_valid = 1'b1;
        mem_wr_resp_in_bits  = 17'h00003;
        mem_rd_req_out_ready = 1'b0;
        tmp = rnd_word(); acc_rd_req_in_0_bits = tmp[RD_REQ_W-1:0];
        acc_rd_req_in_0_valid = 1'b1;
        @(posedge a_clk); #1;
        acc_rd_req_in_0_valid = 1'b0;
        rst = 1'b0;
        @(negedge a_clk);
        check("mid_rst_held", mem_rd_req_out_valid, 1'b1);
        check("mid_rst_resp_gate", {acc_rd_resp_out_1_valid, acc_rd_resp_out_0_valid,
                                    acc_wr_resp_out_1_valid, acc_wr_resp_out_0_valid}, 4'b0000);
        @(posedge a_clk); #1;
        rst = 1'b1;
        mem_rd_req_out_ready = 1'b1;
        @(negedge a_clk);
        check("mid_rst_dropped", mem_rd_req_out_valid, 1'b0);
        check("mid_rst_resp_back", {acc_rd_resp_out_1_valid, acc_wr_resp_out_0_valid}, 2'b11);
        @(posedge a_clk); #1;
        mem_rd_resp_in_valid = 1'b0; mem_wr_resp_in_valid = 1'b0;
        @(negedge a_clk);
        check("rd_sb_empty", 640'(rd_q.size()), 640'd0);
        check("wr_sb_empty", 640'(wr_q.size()), 640'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
